axi_sram_slave: RTL and testbench

// - AXI3 responder backed by a word-organised SRAM array; the target-side end of the core's
//   AXI master port (crossbar m_axi_*). Used as the memory model in SoC sims and as on-chip RAM.
// - Independent read and write engines with single-beat to 16-beat bursts (FIXED/INCR/WRAP).
// - Per-transfer OKAY/SLVERR responses.

---
 rtl/axi_sram_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a 32-bit-word SRAM with independent read and write burst engines.
// Define AXI_SLV_BACKPRESSURE_EN to throttle wready/rvalid to every other cycle.
module axi_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000,
    parameter int          ADDR_W    = 14
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);
    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH) << 2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    logic [31:0] mem [DEPTH];

    logic unused_sig;
    assign unused_sig = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid};

    function automatic logic in_range(input logic [31:0] a);
        return (a - BASE_ADDR) < MEM_BYTES;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [1:0]  sz;
        logic [31:0] step;
        logic [31:0] mask;
        sz   = (size > 3'd2) ? 2'd2 : size[1:0];
        step = 32'd1 << sz;
        mask = ((32'(len) + 32'd1) << sz) - 32'd1;
        case (burst)
            2'b01:   next_addr = a + step;
            2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
            default: next_addr = a;
        endcase
    endfunction

    logic tog;
`ifdef AXI_SLV_BACKPRESSURE_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) tog <= 1'b0;
        else          tog <= ~tog;
    end
`else
    assign tog = 1'b1;
`endif

    // ---------------- write engine ----------------
    w_state_e    w_state, w_state_nx;
    logic [3:0]  w_id, w_len, w_cnt;
    logic [31:0] w_addr;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_err, w_over;
    logic        aw_hs, w_hs, b_hs, w_bad, w_we;

    assign awready = (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA) && tog;
    assign bvalid  = (w_state == W_RESP);
    assign bid     = w_id;
    assign bresp   = (bvalid && w_err) ? 2'b10 : 2'b00;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    // w_over marks beats past awlen: they are swallowed until wlast arrives
    assign w_bad = w_over || (w_burst == 2'b11) || !in_range(w_addr);
    assign w_we  = w_hs && !w_bad;

    always_comb begin
        w_state_nx = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)          w_state_nx = W_DATA;
            W_DATA:  if (w_hs && wlast)  w_state_nx = W_RESP;
            W_RESP:  if (b_hs)           w_state_nx = W_IDLE;
            default:                     w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_over  <= 1'b0;
        end else begin
            w_state <= w_state_nx;
            if (aw_hs) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
                w_over  <= 1'b0;
            end else if (w_hs) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                if (w_cnt == w_len) w_over <= 1'b1;
                else                w_cnt  <= w_cnt + 4'd1;
                if (w_bad || (wlast && (w_cnt != w_len))) w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr[ADDR_W+1:2]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_e    r_state, r_state_nx;
    logic [3:0]  r_id, r_len, r_cnt;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_held;
    logic        ar_hs, r_hs;
    logic        ld_en, ld_ok;
    logic [31:0] ld_addr;
    logic [1:0]  ld_burst;

    assign arready = (r_state == R_IDLE);
    // once raised, rvalid stays up until accepted even if the toggle drops
    assign rvalid  = (r_state == R_DATA) && (r_held || tog);
    assign rlast   = (r_state == R_DATA) && (r_cnt == r_len);
    assign rid     = r_id;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // Beat data is captured at the edge that exposes it, so same-cycle writes are not seen
    always_comb begin
        ld_en    = 1'b0;
        ld_addr  = araddr;
        ld_burst = arburst;
        if (ar_hs) begin
            ld_en = 1'b1;
        end else if (r_hs && !rlast) begin
            ld_en    = 1'b1;
            ld_addr  = next_addr(r_addr, r_len, r_size, r_burst);
            ld_burst = r_burst;
        end
        ld_ok = in_range(ld_addr) && (ld_burst != 2'b11);
    end

    always_comb begin
        r_state_nx = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)         r_state_nx = R_DATA;
            R_DATA:  if (r_hs && rlast) r_state_nx = R_IDLE;
            default:                    r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_held  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            r_state <= r_state_nx;
            r_held  <= rvalid && !rready;
            if (ar_hs) begin
                r_id    <= arid;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_cnt   <= '0;
            end else if (r_hs && !rlast) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (ld_en) begin
                r_addr <= ld_addr;
                rdata  <= ld_ok ? mem[ld_addr[ADDR_W+1:2]] : 32'd0;
                rresp  <= ld_ok ? 2'b00 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised bench for axi_sram_slave: a transaction-level memory model checks every
// B and R handshake, plus directed bursts with hand-computed expectations.
`timescale 1ns/1ps
module tb_axi_sram_slave;
    localparam logic [31:0] BASE = 32'h1fc0_0000;
    localparam logic [31:0] MEMB = 32'h0001_0000;

    logic        aclk = 1'b0, aresetn = 1'b1;
    logic [3:0]  awid = '0, arid = '0, wid = '0, bid, rid, awcache = '0, arcache = '0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [3:0]  awlen = '0, arlen = '0, wstrb = '0;
    logic [2:0]  awsize = '0, arsize = '0, awprot = '0, arprot = '0;
    logic [1:0]  awburst = '0, arburst = '0, awlock = '0, arlock = '0, bresp, rresp;
    logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
    logic        arvalid = 0, arready, rlast, rvalid, rready = 0;

    axi_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        int          len;
        int          size;
        logic [1:0]  burst;
        int          cnt;
        bit          err;
    } ctx_t;

    logic [31:0] mmem [int];          // only words whose full value is known
    ctx_t        wq[$], rq[$];
    logic [5:0]  bexp[$];
    logic [5:0]  b_last;
    logic [32:0] rlog[$];             // {rlast, rdata} per accepted read beat
    logic [31:0] fill [64];

    function automatic bit m_inr(input logic [31:0] a);
        return (a - BASE) < MEMB;
    endfunction
    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction
    function automatic logic [31:0] m_next(input ctx_t c);
        int unsigned step, tot, lo;
        step = 1 << ((c.size > 2) ? 2 : c.size);
        if (c.burst == 2'b01) return c.addr + step;
        if (c.burst == 2'b10) begin
            tot = (c.len + 1) * step;
            lo  = c.addr - (c.addr % tot);
            return lo + ((c.addr - lo + step) % tot);
        end
        return c.addr;
    endfunction

    // compare process: every handshake on B/R checked against the model
    initial begin
        ctx_t        c;
        bit          ok, st_d;
        int          w;
        logic [31:0] v, st_data;
        logic [2:0]  st_misc;
        st_d = 0; st_data = '0; st_misc = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                wq.delete(); rq.delete(); bexp.delete(); st_d = 0;
            end else begin
                if (st_d) chk("r_stall_hold", {rvalid, rdata, rlast, rresp}, {1'b1, st_data, st_misc});
                st_d = rvalid && !rready; st_data = rdata; st_misc = {rlast, rresp};
                if (rvalid && rready) begin
                    rlog.push_back({rlast, rdata});
                    if (rq.size() == 0) chk("r_ctx", rq.size(), 1);
                    else begin
                        c  = rq[0];
                        ok = m_inr(c.addr) && c.burst != 2'b11;
                        chk("rid", rid, c.id);
                        chk("rresp", rresp, ok ? 2'b00 : 2'b10);
                        chk("rlast", rlast, c.cnt == c.len);
                        if (!ok) chk("rdata_err", rdata, 0);
                        else if (mmem.exists(widx(c.addr))) chk("rdata", rdata, mmem[widx(c.addr)]);
                        if (c.cnt == c.len) void'(rq.pop_front());
                        else begin c.addr = m_next(c); c.cnt++; rq[0] = c; end
                    end
                end
                if (wvalid && wready) begin
                    if (wq.size() == 0) chk("w_ctx", wq.size(), 1);
                    else begin
                        c = wq[0];
                        if (c.cnt > c.len || c.burst == 2'b11 || !m_inr(c.addr)) c.err = 1;
                        else begin
                            w = widx(c.addr);
                            if (wstrb == 4'hf) mmem[w] = wdata;
                            else if (mmem.exists(w)) begin
                                v = mmem[w];
                                for (int b = 0; b < 4; b++) if (wstrb[b]) v[b*8 +: 8] = wdata[b*8 +: 8];
                                mmem[w] = v;
                            end
                        end
                        if (wlast) begin
                            if (c.cnt != c.len) c.err = 1;
                            bexp.push_back({c.id, c.err ? 2'b10 : 2'b00});
                            void'(wq.pop_front());
                        end else begin
                            c.addr = m_next(c); c.cnt++; wq[0] = c;
                        end
                    end
                end
                if (bvalid && bready) begin
                    b_last = {bid, bresp};
                    if (bexp.size() == 0) chk("b_ctx", bexp.size(), 1);
                    else begin
                        chk("bid_bresp", {bid, bresp}, bexp[0]);
                        void'(bexp.pop_front());
                    end
                end
                if (awvalid && awready) begin
                    c.id = awid; c.addr = awaddr; c.len = int'(awlen); c.size = int'(awsize);
                    c.burst = awburst; c.cnt = 0; c.err = 0;
                    wq.push_back(c);
                end
                if (arvalid && arready) begin
                    c.id = arid; c.addr = araddr; c.len = int'(arlen); c.size = int'(arsize);
                    c.burst = arburst; c.cnt = 0; c.err = 0;
                    rq.push_back(c);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    logic [31:0] wd [17];
    logic [3:0]  ws [17];
    bit          gaps = 0;
    int          rmode = 0;

    task automatic wr(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                      input logic [2:0] sz, input logic [1:0] bu, input int nb,
                      output int lat, output int blat);
        int t0, tw, tb, n, to;
        bit hs;
        awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1;
        to = 0; t0 = 0; tw = 0; tb = 0;
        do begin
            @(negedge aclk); hs = awready; @(posedge aclk); #1; t0 = cyc; to++;
        end while (!hs && to < 50);
        awvalid = 0;
        if (!hs) chk("aw_timeout", hs, 1);
        n = 0; to = 0;
        while (n < nb && to < 400) begin
            if (!wvalid) wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata = wd[n]; wstrb = ws[n]; wlast = (n == nb - 1);
            @(negedge aclk); hs = wvalid && wready; @(posedge aclk); #1; to++;
            if (hs) begin n++; tw = cyc; wvalid = 0; end
        end
        wvalid = 0; wlast = 0;
        if (n < nb) chk("w_timeout", n, nb);
        hs = 0; to = 0;
        while (!hs && to < 100) begin
            bready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk); hs = bvalid && bready; @(posedge aclk); #1; tb = cyc; to++;
        end
        bready = 0;
        if (!hs) chk("b_timeout", hs, 1);
        lat = tb - t0; blat = tb - tw;
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                      input logic [2:0] sz, input logic [1:0] bu, output int lat);
        int t0, tr, to;
        bit hs, done;
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1;
        to = 0; t0 = 0; tr = 0;
        do begin
            @(negedge aclk); hs = arready; @(posedge aclk); #1; t0 = cyc; to++;
        end while (!hs && to < 50);
        arvalid = 0;
        if (!hs) chk("ar_timeout", hs, 1);
        done = 0; to = 0;
        while (!done && to < 400) begin
            case (rmode)
                0:       rready = 1;
                1:       rready = ~rready;
                default: rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge aclk); hs = rvalid && rready; done = hs && rlast; @(posedge aclk); #1;
            tr = cyc; to++;
        end
        rready = 0;
        if (!done) chk("r_timeout", done, 1);
        lat = tr - t0;
    endtask

    task automatic pick(input int maxlen, output logic [1:0] bu, output logic [3:0] len,
                        output logic [2:0] sz);
        int r;
        r  = $urandom_range(0, 9);
        bu = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        sz = 3'($urandom_range(0, 3));
        if (bu == 2'b10) len = 4'((2 << $urandom_range(0, (maxlen == 15) ? 3 : 2)) - 1);
        else             len = 4'($urandom_range(0, maxlen));
    endtask

    function automatic logic [31:0] pick_addr(input int lo, input int span, input bit oor);
        if (oor && $urandom_range(0, 11) == 0)
            return $urandom_range(0, 1) ? BASE - 32'($urandom_range(1, 16))
                                        : BASE + MEMB - 32'($urandom_range(0, 16));
        return BASE + 32'(lo) + 32'($urandom_range(0, span - 1));
    endfunction

    task automatic rnd_wr(input int lo, input int span, input int maxlen);
        logic [1:0] bu; logic [3:0] len; logic [2:0] sz;
        int nb, l1, l2;
        pick(maxlen, bu, len, sz);
        nb = int'(len) + 1;
        if ($urandom_range(0, 7) == 0) nb = $urandom_range(0, 1) ? nb + 1 : ((nb > 1) ? nb - 1 : 2);
        for (int i = 0; i < 17; i++) begin
            wd[i] = $urandom;
            ws[i] = $urandom_range(0, 1) ? 4'hf : 4'($urandom_range(0, 15));
        end
        wr(4'($urandom_range(0, 15)), pick_addr(lo, span, 1), len, sz, bu, nb, l1, l2);
    endtask

    task automatic rnd_rd(input int lo, input int span, input int maxlen, input bit oor);
        logic [1:0] bu; logic [3:0] len; logic [2:0] sz;
        int l;
        pick(maxlen, bu, len, sz);
        rd(4'($urandom_range(0, 15)), pick_addr(lo, span, oor), len, sz, bu, l);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int lw, lb, lr;
        #2 aresetn = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_ctrl", {awready, arready, wready, bvalid, rvalid, rlast}, 6'b110000);
        chk("rst_ids", {bid, rid, bresp, rresp}, 12'h000);
        chk("rst_rdata", rdata, 32'h0);
        @(posedge aclk); #1 aresetn = 1;

        // known contents for words 0..63
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) begin
                fill[k*16+i] = $urandom; wd[i] = fill[k*16+i]; ws[i] = 4'hf;
            end
            wr(4'(k), BASE + 32'(k*64), 4'd15, 3'd2, 2'b01, 16, lw, lb);
        end

        // single beat write and read-back
        wd[0] = 32'hdeadbeef; ws[0] = 4'hf;
        wr(4'd5, BASE + 32'h10, 4'd0, 3'd2, 2'b01, 1, lw, lb);
        chk("single_b_after_wlast", lb, 1);
        chk("single_b", b_last, {4'd5, 2'b00});
        rlog.delete();
        rd(4'd6, BASE + 32'h10, 4'd0, 3'd2, 2'b01, lr);
        chk("single_r_n", rlog.size(), 1);
        chk("single_r", rlog[0], {1'b1, 32'hdeadbeef});

        // INCR write, strobed partial write, INCR and WRAP read-back
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hf; end
        wr(4'd1, BASE + 32'h20, 4'd3, 3'd2, 2'b01, 4, lw, lb);
        wd[0] = 32'h0000ab00; ws[0] = 4'b0010;
        wr(4'd2, BASE + 32'h24, 4'd0, 3'd2, 2'b01, 1, lw, lb);
        rlog.delete();
        rd(4'd3, BASE + 32'h20, 4'd3, 3'd2, 2'b01, lr);
        chk("incr_n", rlog.size(), 4);
        chk("incr_0", rlog[0], {1'b0, 32'h1});
        chk("incr_1", rlog[1], {1'b0, 32'h0000ab02});
        chk("incr_2", rlog[2], {1'b0, 32'h3});
        chk("incr_3", rlog[3], {1'b1, 32'h4});
        rlog.delete();
        rd(4'd4, BASE + 32'h28, 4'd3, 3'd2, 2'b10, lr);
        chk("wrap_n", rlog.size(), 4);
        chk("wrap_0", rlog[0], {1'b0, 32'h3});
        chk("wrap_1", rlog[1], {1'b0, 32'h4});
        chk("wrap_2", rlog[2], {1'b0, 32'h1});
        chk("wrap_3", rlog[3], {1'b1, 32'h0000ab02});

        // 8-beat read with rready toggling every cycle
        rmode = 1; rlog.delete();
        rd(4'd7, BASE + 32'h80, 4'd7, 3'd2, 2'b01, lr);
        rmode = 0;
        chk("toggle_n", rlog.size(), 8);
        for (int i = 0; i < 8; i++) chk("toggle_beat", rlog[i], {i == 7, fill[32+i]});

        // out-of-range write must not alias onto word 0
        wd[0] = 32'h12345678; ws[0] = 4'hf;
        wr(4'd8, BASE + MEMB, 4'd0, 3'd2, 2'b01, 1, lw, lb);
        chk("oor_bresp", b_last, {4'd8, 2'b10});
        rlog.delete();
        rd(4'd8, BASE, 4'd0, 3'd2, 2'b01, lr);
        chk("oor_unchanged", rlog[0], {1'b1, fill[0]});

        // length mismatches: early and late wlast
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hc0de_0000 + 32'(i); ws[i] = 4'hf; end
        wr(4'd9, BASE + 32'h60, 4'd2, 3'd2, 2'b01, 2, lw, lb);
        chk("short_bresp", b_last, {4'd9, 2'b10});
        wr(4'd10, BASE + 32'h70, 4'd1, 3'd2, 2'b01, 3, lw, lb);
        chk("long_bresp", b_last, {4'd10, 2'b10});
        rlog.delete();
        rd(4'd10, BASE + 32'h78, 4'd0, 3'd2, 2'b01, lr);
        chk("long_no_extra_write", rlog[0], {1'b1, fill[30]});

        // concurrent read and write on disjoint regions
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
        fork
            wr(4'd11, BASE + 32'h40, 4'd3, 3'd2, 2'b01, 4, lw, lb);
            rd(4'd12, BASE + 32'ha0, 4'd3, 3'd2, 2'b01, lr);
        join
`ifndef AXI_SLV_BACKPRESSURE_EN
        chk("conc_write_lat", lw, 5);
        chk("conc_read_lat", lr, 4);
`endif

        // reset in the middle of a write burst keeps the committed beats
        awid = 4'd13; awaddr = BASE + 32'hc0; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1;
        @(posedge aclk); #1 awvalid = 0;
        wvalid = 1; wstrb = 4'hf; wdata = 32'haaaa_0001;
        @(posedge aclk); #1 wdata = 32'haaaa_0002;
        @(posedge aclk); #1 wvalid = 0; aresetn = 0;
        @(negedge aclk);
        chk("rst_mid_ctrl", {awready, wready, bvalid, arready}, 4'b1001);
        @(posedge aclk); #1 aresetn = 1;
        rlog.delete();
        rd(4'd14, BASE + 32'hc0, 4'd3, 3'd2, 2'b01, lr);
        chk("rst_mid_n", rlog.size(), 4);
        chk("rst_mid_b0", rlog[0], {1'b0, 32'haaaa_0001});
        chk("rst_mid_b2", rlog[2], {1'b0, fill[50]});

        // random sequential traffic with gaps and back-pressure
        gaps = 1; rmode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1)) rnd_wr(0, 256, 15);
            else                      rnd_rd(0, 256, 15, 1);
        end
        // random concurrent traffic: writes below 0x80, reads above
        for (int i = 0; i < 40; i++) begin
            fork
                rnd_wr(0, 96, 7);
                rnd_rd(128, 96, 7, 0);
            join
        end
        repeat (4) @(posedge aclk);
        chk("queues_drained", wq.size() + rq.size() + bexp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
